// File: rtl/sigma_pkg.sv
// Shared types and legality checks for the multi-lane SHA-2 sigma stage.
package sigma_pkg;

  // Per-lane function select: small sigma ends in a logical shift, big sigma in a rotate.
  typedef enum logic {
    SIGMA_SMALL = 1'b0,
    SIGMA_BIG   = 1'b1
  } sigma_mode_e;

  // Job control states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sigma_state_e;

  // Supported word widths (SHA-256 and SHA-512) and lane-count limits.
  localparam int SIGMA_W32    = 32;
  localparam int SIGMA_W64    = 64;
  localparam int SIGMA_MIN_CH = 1;
  localparam int SIGMA_MAX_CH = 8;

  function automatic bit sigma_width_ok(input int w);
    return (w == SIGMA_W32) || (w == SIGMA_W64);
  endfunction

  function automatic bit sigma_lanes_ok(input int n);
    return (n >= SIGMA_MIN_CH) && (n <= SIGMA_MAX_CH);
  endfunction

endpackage

// File: rtl/sigma_stage_multi_if.sv
// Streaming word-set handshake between the sigma stage and its neighbours.
// The master side produces input word sets and consumes results; the slave
// side is the sigma stage itself.
interface sigma_stage_multi_if #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 2
) ();

  logic [N_CH*DATA_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_CH*DATA_W-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/sigma_lane.sv
// One rotate/shift/XOR lane: stage 1 holds the three rotated/shifted copies,
// stage 2 holds their XOR. Pure datapath; the caller owns valid tracking and
// supplies the advance enable.
module sigma_lane
  import sigma_pkg::*;
#(
  parameter  int DATA_W  = 32,
  localparam int SHIFT_W = $clog2(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_W-1:0]    x,
  input  logic [3*SHIFT_W-1:0] amt,
  input  sigma_mode_e          mode,
  output logic [DATA_W-1:0]    y
);

  // Rotate right: take the low word of the doubled operand shifted right.
  // A zero amount returns the operand unchanged.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v,
                                             input logic [SHIFT_W-1:0] k);
    logic [2*DATA_W-1:0] dbl;
    dbl = {v, v} >> k;
    return dbl[DATA_W-1:0];
  endfunction

  // Logical shift right with zero fill.
  function automatic logic [DATA_W-1:0] shr(input logic [DATA_W-1:0] v,
                                            input logic [SHIFT_W-1:0] k);
    return v >> k;
  endfunction

  logic [SHIFT_W-1:0] amt_a;
  logic [SHIFT_W-1:0] amt_b;
  logic [SHIFT_W-1:0] amt_c;

  assign amt_a = amt[SHIFT_W-1:0];
  assign amt_b = amt[2*SHIFT_W-1:SHIFT_W];
  assign amt_c = amt[3*SHIFT_W-1:2*SHIFT_W];

  logic [DATA_W-1:0] term_a_p1;
  logic [DATA_W-1:0] term_b_p1;
  logic [DATA_W-1:0] term_c_p1;
  logic [DATA_W-1:0] y_p2;

  // ---- stage 1: rotated / shifted copies of the input word ----
  // Capture the three terms whenever the pipeline advances.
  always_ff @(posedge clk) begin
    if (en) begin
      term_a_p1 <= rotr(x, amt_a);
      term_b_p1 <= rotr(x, amt_b);
      term_c_p1 <= (mode == SIGMA_BIG) ? rotr(x, amt_c) : shr(x, amt_c);
    end
  end

  // ---- stage 2: XOR of the three terms, visible at the unit output ----
  // Output word is cleared on reset so the bus idles at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      y_p2 <= '0;
    end else if (en) begin
      y_p2 <= term_a_p1 ^ term_b_p1 ^ term_c_p1;
    end
  end

  assign y = y_p2;

endmodule

// File: rtl/sigma_stage_multi.sv
// N_CH-lane SHA-2 sigma functional unit with a two-stage valid/ready pipeline.
// A job starts on a single-cycle run pulse that latches lane amounts, lane
// modes and the output count; the job ends after len output handshakes, at
// which point busy drops and done stays high until the next run.
module sigma_stage_multi
  import sigma_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int N_CH    = 2,
  parameter  int LEN_W   = 16,
  localparam int SHIFT_W = $clog2(DATA_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [LEN_W-1:0]          len,
  input  logic [N_CH*3*SHIFT_W-1:0] cfg_amt,
  input  logic [N_CH-1:0]           cfg_mode,
  sigma_stage_multi_if.slave        bus,
  output logic                      busy,
  output logic                      done
);

  if (!sigma_width_ok(DATA_W)) begin : g_bad_width
    $error("sigma_stage_multi: DATA_W must be 32 or 64");
  end

  if (!sigma_lanes_ok(N_CH)) begin : g_bad_lanes
    $error("sigma_stage_multi: N_CH must be in 1..8");
  end

  sigma_state_e state_q;
  sigma_state_e state_d;
  logic         done_q;
  logic         done_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic         vld_p1;
  logic         vld_p1_d;
  logic         vld_p2;
  logic         vld_p2_d;

  // Job configuration, frozen for the whole job.
  logic [LEN_W-1:0]          len_q;
  logic [N_CH*3*SHIFT_W-1:0] amt_q;
  logic [N_CH-1:0]           mode_q;

  logic en;
  logic in_ready;
  logic accept;
  logic hs;
  logic last_hs;
  logic [N_CH*DATA_W-1:0] out_w;

  // The whole pipeline moves together unless a result is waiting on a stalled
  // consumer; in_ready therefore follows out_ready combinationally.
  assign en       = !vld_p2 || bus.out_ready;
  assign busy     = (state_q == RUN);
  assign in_ready = en && busy;
  assign accept   = bus.in_valid && in_ready;
  assign hs       = vld_p2 && bus.out_ready;
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign last_hs  = hs && (cnt_inc == len_q);

  // Next-state, counter and valid-bit decisions; run overrides everything.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    vld_p1_d = vld_p1;
    vld_p2_d = vld_p2;

    if (en) begin
      vld_p1_d = accept;
      vld_p2_d = vld_p1;
    end

    if (hs) begin
      cnt_d = cnt_inc;
    end

    case (state_q)
      IDLE: begin
      end
      RUN: begin
        // Final handshake: anything still in flight belongs to no job.
        if (last_hs) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          vld_p1_d = 1'b0;
          vld_p2_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new run flushes the pipeline and restarts counting; a zero-length job
    // completes immediately without producing outputs.
    if (run) begin
      cnt_d    = '0;
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
      if (len == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
        done_d  = 1'b0;
      end
    end
  end

  // Control registers: state, completion flag, output counter, stage valids.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      vld_p1  <= vld_p1_d;
      vld_p2  <= vld_p2_d;
    end
  end

  // Configuration is sampled only on run; pin changes mid-job have no effect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q  <= '0;
      amt_q  <= '0;
      mode_q <= '0;
    end else if (run) begin
      len_q  <= len;
      amt_q  <= cfg_amt;
      mode_q <= cfg_mode;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    sigma_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .x    (bus.in_data[i*DATA_W +: DATA_W]),
      .amt  (amt_q[i*3*SHIFT_W +: 3*SHIFT_W]),
      .mode (sigma_mode_e'(mode_q[i])),
      .y    (out_w[i*DATA_W +: DATA_W])
    );
  end

  assign bus.out_data  = out_w;
  assign bus.out_valid = vld_p2;
  assign bus.in_ready  = in_ready;
  assign done          = done_q;

endmodule

// File: tb/tb_sigma_stage_multi.sv
// Scoreboard bench for sigma_stage_multi: a 32-bit two-lane unit carries the
// main traffic, a 64-bit single-lane unit covers the SHA-512 width.
module tb_sigma_stage_multi;
  import sigma_pkg::*;

  localparam int W   = 32;
  localparam int NC  = 2;
  localparam int LW  = 16;
  localparam int SW  = 5;
  localparam int W64 = 64;
  localparam int SW64 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                run;
  logic [LW-1:0]       len;
  logic [NC*3*SW-1:0]  cfg_amt;
  logic [NC-1:0]       cfg_mode;
  logic                busy;
  logic                done;

  logic                run64;
  logic [LW-1:0]       len64;
  logic [3*SW64-1:0]   amt64;
  logic [0:0]          mode64;
  logic                busy64;
  logic                done64;

  sigma_stage_multi_if #(.DATA_W(W),   .N_CH(NC)) bus ();
  sigma_stage_multi_if #(.DATA_W(W64), .N_CH(1))  bus64 ();

  sigma_stage_multi #(.DATA_W(W), .N_CH(NC), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .len      (len),
    .cfg_amt  (cfg_amt),
    .cfg_mode (cfg_mode),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  sigma_stage_multi #(.DATA_W(W64), .N_CH(1), .LEN_W(LW)) dut64 (
    .clk      (clk),
    .rst      (rst),
    .run      (run64),
    .len      (len64),
    .cfg_amt  (amt64),
    .cfg_mode (mode64),
    .bus      (bus64),
    .busy     (busy64),
    .done     (done64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_rotr(input logic [63:0] x, input int k, input int w);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < w; j++) r[j] = x[(j + k) % w];
    return r;
  endfunction

  function automatic logic [63:0] m_lane(input logic [63:0] x, input int a, input int b,
                                         input int c, input bit big, input int w);
    logic [63:0] third;
    if (big) third = m_rotr(x, c, w);
    else     third = x >> c;
    return m_rotr(x, a, w) ^ m_rotr(x, b, w) ^ third;
  endfunction

  int m_a[NC];
  int m_b[NC];
  int m_c[NC];
  bit m_big[NC];
  int m64_a, m64_b, m64_c;
  bit m64_big;

  function automatic logic [63:0] exp32(input logic [63:0] d);
    logic [63:0] r0, r1;
    r0 = m_lane({32'h0, d[31:0]},  m_a[0], m_b[0], m_c[0], m_big[0], 32);
    r1 = m_lane({32'h0, d[63:32]}, m_a[1], m_b[1], m_c[1], m_big[1], 32);
    return {r1[31:0], r0[31:0]};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [63:0] exp_q[$];
  logic [63:0] exp64_q[$];

  // ---------------- consumer ready pattern ----------------
  int rdy_mode = 0;
  int rdy_ph = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    bus.out_ready   = 1'b1;
    bus64.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = pat[rdy_ph % 4];
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
      rdy_ph++;
    end
  end

  // ---------------- monitors ----------------
  bit          mon_en = 1'b0;
  int          hs_count = 0;
  int          outs_left = 0;
  bit          check_done_next = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        prev_stall      = 1'b0;
        check_done_next = 1'b0;
      end else if (mon_en) begin
        if (check_done_next) begin
          check("done_after_last_hs", {busy, done}, 2'b01);
          check_done_next = 1'b0;
        end
        if (prev_stall) begin
          check("stall_valid_hold", bus.out_valid, 1'b1);
          check("stall_data_hold", bus.out_data, prev_data);
        end
        if (busy) check("in_ready_vs_stall", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        else      check("in_ready_when_idle", bus.in_ready, 1'b0);
        if (bus.out_valid && bus.out_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_output", bus.out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e);
          end
          if (outs_left > 0) begin
            outs_left--;
            if (outs_left == 0) check_done_next = 1'b1;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
      end
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst && bus64.out_valid && bus64.out_ready) begin
        if (exp64_q.size() == 0) begin
          check("unexpected_output64", bus64.out_valid, 1'b0);
        end else begin
          e = exp64_q.pop_front();
          check("out_data64", bus64.out_data, e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_job(input int l, input int a0, input int b0, input int c0,
                           input int a1, input int b1, input int c1, input logic [1:0] md);
    m_a[0] = a0; m_b[0] = b0; m_c[0] = c0; m_big[0] = md[0];
    m_a[1] = a1; m_b[1] = b1; m_c[1] = c1; m_big[1] = md[1];
    run      = 1'b1;
    len      = LW'(l);
    cfg_amt  = {5'(c1), 5'(b1), 5'(a1), 5'(c0), 5'(b0), 5'(a0)};
    cfg_mode = md;
    @(posedge clk);
    exp_q.delete();
    outs_left = l;
    #1;
    run      = 1'b0;
    len      = LW'($urandom);
    cfg_amt  = 30'($urandom);
    cfg_mode = 2'($urandom);
    @(negedge clk);
    if (l == 0) check("len0_done_next_cycle", {busy, done}, 2'b01);
    else        check("run_sets_busy", {busy, done}, 2'b10);
    @(posedge clk);
    #1;
  endtask

  task automatic start_rand_job(input int l);
    start_job(l, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              2'($urandom));
  endtask

  task automatic send32(input logic [63:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(exp32(d));
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    fail_now("send32_timeout");
  endtask

  task automatic wait_done(input int max_cyc);
    for (int g = 0; g < max_cyc; g++) begin
      @(negedge clk);
      if (done) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    fail_now("done_timeout");
  endtask

  // Single-word job with explicit latency, value and completion checks.
  task automatic one_word32(input logic [63:0] d, input logic [63:0] want, input string nm);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check({nm, "_accept"}, bus.in_ready, 1'b1);
    exp_q.push_back(exp32(d));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_t1_not_valid"}, bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({nm, "_t2_valid"}, bus.out_valid, 1'b1);
    check({nm, "_t2_data"}, bus.out_data, want);
    check({nm, "_t2_not_done"}, done, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({nm, "_done"}, {busy, done}, 2'b01);
    @(posedge clk);
    #1;
  endtask

  task automatic start64(input int l, input int a, input int b, input int c, input bit big);
    m64_a = a; m64_b = b; m64_c = c; m64_big = big;
    run64  = 1'b1;
    len64  = LW'(l);
    amt64  = {6'(c), 6'(b), 6'(a)};
    mode64 = big;
    @(posedge clk);
    exp64_q.delete();
    #1;
    run64 = 1'b0;
    amt64 = 18'($urandom);
  endtask

  task automatic send64(input logic [63:0] d);
    bus64.in_data  = d;
    bus64.in_valid = 1'b1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (bus64.in_ready) begin
        exp64_q.push_back(m_lane(d, m64_a, m64_b, m64_c, m64_big, 64));
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    fail_now("send64_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int hs0;
    int hs1;
    rst = 1'b0; run = 1'b0; len = '0; cfg_amt = '0; cfg_mode = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    run64 = 1'b0; len64 = '0; amt64 = '0; mode64 = '0;
    bus64.in_valid = 1'b0; bus64.in_data = '0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_data", bus.out_data, 64'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed SHA-256 vectors.
    start_job(1, 7, 18, 3, 2, 13, 22, 2'b10);
    one_word32({32'h0000_0001, 32'h0000_0001}, 64'h40080400_02004000, "vec_sigma0_Sigma");
    start_job(1, 17, 19, 10, 2, 13, 22, 2'b10);
    one_word32({32'h0000_0001, 32'h0000_0000}, 64'h40080400_00000000, "vec_zero_lane");

    // Words offered while idle are refused.
    bus.in_valid = 1'b1;
    bus.in_data  = rnd64();
    @(negedge clk);
    check("idle_not_accepted", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    // Backpressure stream with ready pattern 1,0,0,1.
    rdy_mode = 1;
    start_rand_job(8);
    hs0 = hs_count;
    for (int i = 0; i < 8; i++) send32(rnd64());
    bus.in_valid = 1'b0;
    wait_done(300);
    check("bp_handshakes", 32'(hs_count - hs0), 32'd8);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    rdy_mode = 0;

    // Zero-length job.
    hs0 = hs_count;
    start_rand_job(0);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("len0_no_outputs", 32'(hs_count - hs0), 32'd0);
    check("len0_done_held", {busy, done}, 2'b01);
    @(posedge clk);
    #1;

    // Re-run after three outputs: flush, restart count, new amounts.
    start_job(8, 1, 2, 3, 4, 5, 6, 2'b00);
    hs0 = hs_count;
    for (int g = 0; g < 40 && (hs_count - hs0) < 3; g++) send32(rnd64());
    bus.in_valid = 1'b0;
    check("rerun_three_seen", 32'((hs_count - hs0) >= 3), 32'd1);
    start_job(8, 9, 21, 30, 11, 0, 25, 2'b11);
    hs1 = hs_count;
    for (int i = 0; i < 8; i++) send32(rnd64());
    bus.in_valid = 1'b0;
    wait_done(300);
    check("rerun_handshakes", 32'(hs_count - hs1), 32'd8);
    check("rerun_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random jobs under random backpressure.
    rdy_mode = 2;
    for (int j = 0; j < 4; j++) begin
      int l;
      l = $urandom_range(1, 6);
      start_rand_job(l);
      hs0 = hs_count;
      for (int i = 0; i < l; i++) send32(rnd64());
      bus.in_valid = 1'b0;
      wait_done(400);
      check("rand_handshakes", 32'(hs_count - hs0), 32'(l));
    end
    rdy_mode = 0;

    // Reset in the middle of a job, with run in the same cycle.
    start_rand_job(8);
    for (int i = 0; i < 3; i++) send32(rnd64());
    bus.in_valid = 1'b0;
    rst = 1'b0;
    run = 1'b1;
    len = 16'd5;
    outs_left = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    run = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_stays_idle", {busy, done}, 2'b00);
    end
    @(posedge clk);
    #1;

    // SHA-512 width.
    start64(1, 1, 8, 7, 1'b0);
    bus64.in_data  = 64'h1;
    bus64.in_valid = 1'b1;
    @(negedge clk);
    check("w64_accept", bus64.in_ready, 1'b1);
    exp64_q.push_back(m_lane(64'h1, m64_a, m64_b, m64_c, m64_big, 64));
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w64_t2_valid", bus64.out_valid, 1'b1);
    check("w64_t2_data", bus64.out_data, 64'h8100_0000_0000_0000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w64_done", {busy64, done64}, 2'b01);
    @(posedge clk);
    #1;
    start64(3, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), 1'b1);
    for (int i = 0; i < 3; i++) send64(rnd64());
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("w64_rand_done", {busy64, done64}, 2'b01);
    check("w64_queue_empty", 32'(exp64_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
